// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles into NIBBLES-wide words, first nibble in the top bits.
// Words close when full or on in_last; one output register with valid/ready handshake.
module nibble_packer #(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned W       = 4 * NIBBLES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     in_data,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic [W-1:0]                   out_data,
    output logic [$clog2(NIBBLES+1)-1:0]   out_count,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int unsigned CntW = $clog2(NIBBLES);
    localparam int unsigned OcW  = $clog2(NIBBLES + 1);
    localparam int unsigned AccW = W - 4;
    localparam logic [CntW-1:0] CntLast = CntW'(NIBBLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [OcW-1:0]  out_count_q, out_count_d;
    logic            out_last_q, out_last_d;
    logic            out_valid_q, out_valid_d;

    logic            in_fire;
    logic            out_fire;
    logic            closing;
    logic [W-1:0]    word;
    logic [CntW-1:0] gap;

    // Ready depends only on the output register, never on the input side.
    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign closing  = in_fire && (in_last || (cnt_q == CntLast));

    // Collected nibbles sit right-aligned; gap nibbles of shift left-align the word.
    assign word = {acc_q, in_data};
    assign gap  = CntLast - cnt_q;

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            if (closing) begin
                out_data_d  = word << {gap, 2'b00};
                out_count_d = OcW'(cnt_q) + OcW'(1);
                out_last_d  = in_last;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                acc_d       = '0;
            end else begin
                acc_d = (acc_q << 4) | AccW'(in_data);
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer (NIBBLES=4): full, partial, backpressure,
// streaming, back-to-back closes and asynchronous reset mid-word.
module tb_nibble_packer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_data;
    logic [2:0]  out_count;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    nibble_packer #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] d, input logic [2:0] c,
                            input logic l, input logic v);
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".count"}, 32'(out_count), 32'(c));
        chk({tag, ".last"},  32'(out_last),  32'(l));
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    endtask

    // Called between edges; returns 1 time unit after the accepting edge.
    task automatic send(input logic [3:0] nib, input logic last);
        in_data  = nib;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'bxxxx;
        in_last  = 1'bx;
    endtask

    initial begin
        logic [15:0] exp_word;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        #3;
        chk_word("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full word
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        chk("full.nb_valid", 32'(out_valid), 32'd0);
        send(4'hD, 1'b0);
        chk_word("full", 16'hABCD, 3'd4, 1'b0, 1'b1);
        // Idle cycle with X on data/last: word drains and holds its contents
        @(posedge clk);
        #1;
        chk_word("drain", 16'hABCD, 3'd4, 1'b0, 1'b0);

        // Partial word, then the next nibble starts a fresh word
        send(4'h3, 1'b0);
        send(4'h7, 1'b1);
        chk_word("partial", 16'h3700, 3'd2, 1'b1, 1'b1);
        send(4'h1, 1'b0);
        chk("partial.pop", 32'(out_valid), 32'd0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        chk_word("w1234", 16'h1234, 3'd4, 1'b0, 1'b1);

        // Backpressure: word held, 0x5 waits on in_valid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h5;
        in_last   = 1'b0;
        #1;
        chk("bp.in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold_data", 32'(out_data), 32'h1234);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.in_ready_hold", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp.popped", 32'(out_valid), 32'd0);
        send(4'h6, 1'b0);
        send(4'h7, 1'b0);
        send(4'h8, 1'b0);
        chk_word("w5678", 16'h5678, 3'd4, 1'b0, 1'b1);

        // Single-nibble word, then back-to-back closes with no bubble
        send(4'h9, 1'b1);
        chk_word("single", 16'h9000, 3'd1, 1'b1, 1'b1);
        send(4'h6, 1'b1);
        chk_word("b2b", 16'h6000, 3'd1, 1'b1, 1'b1);

        // Full word closed by in_last
        send(4'h1, 1'b0);
        chk("fl.pop", 32'(out_valid), 32'd0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'hF, 1'b1);
        chk_word("fulllast", 16'h123F, 3'd4, 1'b1, 1'b1);

        // Streaming 32 nibbles back to back
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_data = 4'(i);
            #1;
            chk("stream.in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("stream.valid", 32'(out_valid), 32'((i % 4) == 3));
            if ((i % 4) == 3) begin
                exp_word = {4'(i - 3), 4'(i - 2), 4'(i - 1), 4'(i)};
                chk("stream.data", 32'(out_data), 32'(exp_word));
            end
        end
        in_valid = 1'b0;
        in_data  = 4'bxxxx;
        in_last  = 1'bx;

        // Reset mid-word: partial E,F and held output discarded
        send(4'hE, 1'b0);
        send(4'hF, 1'b0);
        chk("rst.pre_data", 32'(out_data), 32'hCDEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk_word("rst.async", 16'h0000, 3'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        chk("rst.no_early", 32'(out_valid), 32'd0);
        send(4'h4, 1'b0);
        chk_word("rst.w1234", 16'h1234, 3'd4, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per output word (legal range 2..8).
REQ-002 The block SHALL have parameter W, default 4*NIBBLES, giving the output word width; W is derived and not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_data  input  4  unsigned nibble.
REQ-006 in_valid  input  1  in_data/in_last qualified.
REQ-007 in_last  input  1  nibble closes the current word, whether the word is full or partial.
REQ-008 in_ready  output  1  block accepts the nibble this cycle.
REQ-009 out_data  output  W  packed word; first-accepted nibble in bits [W-1:W-4].
REQ-010 out_count  output  clog2(NIBBLES+1)  number of valid nibbles in out_data (1..NIBBLES).
REQ-011 out_last  output  1  word was closed by in_last.
REQ-012 out_valid  output  1  out_data/out_count/out_last qualified.
REQ-013 out_ready  input  1  consumer accepts the word.

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), a purely combinational function of registered out_valid and out_ready; it has no dependency on in_valid or in_last.
REQ-016 Internal nibble counter cnt (0..NIBBLES-1) and accumulator acc (W-4 bits) SHALL hold the nibbles received so far for the open word.
REQ-017 On an input transfer with cnt < NIBBLES-1 and in_last=0: acc shifts left 4 and takes in_data in the low nibble; cnt increments; outputs are unchanged.
REQ-018 An input transfer with cnt = NIBBLES-1, or with in_last=1, SHALL close the word on that edge, with these updates:
- out_data = {acc nibbles, in_data}, left-aligned, with the low (NIBBLES-1-cnt)*4 bits zero;
- out_count = cnt+1;
- out_last = in_last;
- out_valid = 1;
- cnt = 0 and acc = 0.
REQ-019 Latency SHALL be one cycle: the word is valid on the edge that accepts the closing nibble.
REQ-020 With in_last=1 and cnt=NIBBLES-1, the result SHALL be a full word with out_last=1.
REQ-021 With in_last=1 and cnt=0, the result SHALL be a one-nibble word (out_count=1).
REQ-022 On an output transfer with no closing input transfer in the same cycle, out_valid SHALL clear; out_data/out_count/out_last retain their values.
REQ-023 If an output transfer and a closing input transfer occur in the same cycle, the new word SHALL load and out_valid SHALL stay 1, with no bubble.
REQ-024 While out_valid=1 and out_ready=0, no nibble SHALL be accepted, and acc, cnt and all outputs SHALL hold.
REQ-025 Sustained throughput SHALL be one nibble per cycle, i.e. one word per NIBBLES cycles, while out_ready=1.
REQ-026 in_data/in_last SHALL be ignored whenever no input transfer occurs; X on them with in_valid=0 SHALL NOT propagate.

Reset
REQ-027 While rst_n=0, regardless of clk:
- out_valid = 0, out_data = 0, out_count = 0, out_last = 0;
- cnt = 0, acc = 0.
REQ-028 After reset, in_ready SHALL be 1.
REQ-029 Reset asserted mid-word SHALL discard any partially assembled nibbles and any pending output word; the first nibble after release starts a new word at bits [W-1:W-4].

Verification
REQ-030 Full word: out_ready=1; nibbles 0xA,0xB,0xC,0xD on consecutive cycles, in_last=0 -> one cycle after 0xD, out_data=0xABCD, out_count=4, out_last=0, out_valid=1 for one cycle.
REQ-031 Partial word: nibbles 0x3, then 0x7 with in_last=1 -> out_data=0x3700, out_count=2, out_last=1; the next nibble 0x1 starts a new word.
REQ-032 Backpressure: out_ready=0 after word 0x1234 is produced -> in_ready=0, in_valid held with 0x5; output and acc stable for 10 cycles; raise out_ready -> 0x1234 transfers, and 0x5 is accepted that same cycle.
REQ-033 Streaming: out_ready=1; 32 back-to-back nibbles 0x0..0xF repeated -> words 0x0123, 0x4567, 0x89AB, 0xCDEF, ... with no gap cycles on in_ready.
REQ-034 Reset mid-word: accept 0xE,0xF, pulse rst_n low asynchronously between clock edges -> outputs immediately 0; then 0x1,0x2,0x3,0x4 -> 0x1234, not containing 0xE/0xF.
REQ-035 Single-nibble last: cnt=0, nibble 0x9 with in_last=1 -> out_data=0x9000, out_count=1, out_last=1.
